slot_sensor_conditioner: RTL and testbench

// - Upstream front end for the parking display stage: turns raw slot switches/sensors into clean, debounced

---
 rtl/slot_sensor_conditioner.sv | 150 +++++++++++++++
 tb/tb_slot_sensor_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/slot_sensor_conditioner.sv
// Slot sensor conditioner: per-slot 2-FF synchroniser, debounce FSM, arrive/depart pulses and occupancy counts.
// Optional PARK_TALLY_EN adds a saturating total_entries counter of accepted arrivals.
module slot_sensor_conditioner #(
    parameter int NUM_SLOTS  = 4,
    parameter int DEB_CYCLES = 1000000,
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] slots_raw,
    output logic [NUM_SLOTS-1:0] slots_clean,
    output logic [NUM_SLOTS-1:0] arrive,
    output logic [NUM_SLOTS-1:0] depart,
    output logic [CNT_W-1:0]     occ_count,
    output logic [CNT_W-1:0]     free_count,
    output logic                 full,
    output logic                 empty
`ifdef PARK_TALLY_EN
    ,
    output logic [7:0]           total_entries
`endif
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_ARRIVING = 2'd1,
        S_OCCUPIED = 2'd2,
        S_LEAVING  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_SLOTS; k++) begin
            acc = acc + CNT_W'(v[k]);
        end
        return acc;
    endfunction

    state_t               state_q [NUM_SLOTS];
    logic [DEB_W-1:0]     cnt_q   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] sync1_q;
    logic [NUM_SLOTS-1:0] sync2_q;
    logic [NUM_SLOTS-1:0] clean_q;
    logic [NUM_SLOTS-1:0] arrive_q;
    logic [NUM_SLOTS-1:0] depart_q;
    logic [CNT_W-1:0]     occ_s;

    // Synchroniser and per-slot debounce FSMs; a glitch that ends before the count completes returns silently.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync1_q  <= {NUM_SLOTS{1'b0}};
            sync2_q  <= {NUM_SLOTS{1'b0}};
            clean_q  <= {NUM_SLOTS{1'b0}};
            arrive_q <= {NUM_SLOTS{1'b0}};
            depart_q <= {NUM_SLOTS{1'b0}};
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= S_EMPTY;
                cnt_q[i]   <= {DEB_W{1'b0}};
            end
        end else begin
            sync1_q  <= slots_raw;
            sync2_q  <= sync1_q;
            arrive_q <= {NUM_SLOTS{1'b0}};
            depart_q <= {NUM_SLOTS{1'b0}};
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case (state_q[i])
                    S_EMPTY: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= S_ARRIVING;
                            cnt_q[i]   <= {DEB_W{1'b0}};
                        end
                    end
                    S_ARRIVING: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= S_EMPTY;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]  <= S_OCCUPIED;
                            clean_q[i]  <= 1'b1;
                            arrive_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + DEB_W'(1);
                        end
                    end
                    S_OCCUPIED: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= S_LEAVING;
                            cnt_q[i]   <= {DEB_W{1'b0}};
                        end
                    end
                    S_LEAVING: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= S_OCCUPIED;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]  <= S_EMPTY;
                            clean_q[i]  <= 1'b0;
                            depart_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + DEB_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= S_EMPTY;
                        cnt_q[i]   <= {DEB_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Counts are derived from registered occupancy bits only, so they never glitch.
    always_comb begin
        occ_s = popcount(clean_q);
    end

    assign slots_clean = clean_q;
    assign arrive      = arrive_q;
    assign depart      = depart_q;
    assign occ_count   = occ_s;
    assign free_count  = CNT_W'(NUM_SLOTS) - occ_s;
    assign full        = (occ_s == CNT_W'(NUM_SLOTS));
    assign empty       = (occ_s == {CNT_W{1'b0}});

`ifdef PARK_TALLY_EN
    logic [7:0] tally_q;
    logic [8:0] tally_sum_s;

    // Sum is one bit wider than the tally so saturation can be detected from the carry.
    always_comb begin
        tally_sum_s = {1'b0, tally_q} + 9'(popcount(arrive_q));
    end

    // Saturating arrival tally; departures never decrement it.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tally_q <= 8'd0;
        end else if (tally_sum_s[8]) begin
            tally_q <= 8'hFF;
        end else begin
            tally_q <= tally_sum_s[7:0];
        end
    end

    assign total_entries = tally_q;
`endif

endmodule

// File: tb/tb_slot_sensor_conditioner.sv
// Self-checking bench for slot_sensor_conditioner (NUM_SLOTS=4, DEB_CYCLES=4): directed steps plus random
// stimulus against a run-length reference model. Tally checks are built when PARK_TALLY_EN is defined.
module tb_slot_sensor_conditioner;

    localparam int NS  = 4;
    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       rst;
    logic [3:0] slots_raw;
    logic [3:0] slots_clean;
    logic [3:0] arrive;
    logic [3:0] depart;
    logic [2:0] occ_count;
    logic [2:0] free_count;
    logic       full;
    logic       empty;
`ifdef PARK_TALLY_EN
    logic [7:0] total_entries;
`endif

    slot_sensor_conditioner #(.NUM_SLOTS(NS), .DEB_CYCLES(DEB)) dut (
        .clock       (clock),
        .rst         (rst),
        .slots_raw   (slots_raw),
        .slots_clean (slots_clean),
        .arrive      (arrive),
        .depart      (depart),
        .occ_count   (occ_count),
        .free_count  (free_count),
        .full        (full),
        .empty       (empty)
`ifdef PARK_TALLY_EN
        ,
        .total_entries (total_entries)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: raw is seen two edges late; a slot flips once the seen level has
    // disagreed with the accepted level for DEB+1 consecutive edges.
    logic [3:0] h1, h2;
    logic [3:0] m_clean, m_arr, m_dep;
    int         run [NS];
    int         m_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h1 = 4'd0; h2 = 4'd0;
        m_clean = 4'd0; m_arr = 4'd0; m_dep = 4'd0;
        for (int i = 0; i < NS; i++) run[i] = 0;
        m_total = 0;
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        logic [3:0] old_arr;
        int         t;
        seen    = h2;
        old_arr = m_arr;
        h2 = h1;
        h1 = slots_raw;
        m_arr = 4'd0;
        m_dep = 4'd0;
        for (int i = 0; i < NS; i++) begin
            if (seen[i] !== m_clean[i]) begin
                run[i]++;
                if (run[i] == DEB + 1) begin
                    m_clean[i] = seen[i];
                    if (seen[i]) m_arr[i] = 1'b1;
                    else         m_dep[i] = 1'b1;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        t = m_total + $countones(old_arr);
        m_total = (t > 255) ? 255 : t;
    endtask

    task automatic check_all();
        int occ;
        occ = $countones(m_clean);
        chk("slots_clean", 32'(slots_clean), 32'(m_clean));
        chk("arrive",      32'(arrive),      32'(m_arr));
        chk("depart",      32'(depart),      32'(m_dep));
        chk("occ_count",   32'(occ_count),   32'(occ));
        chk("free_count",  32'(free_count),  32'(NS - occ));
        chk("full",        32'(full),        32'(occ == NS));
        chk("empty",       32'(empty),       32'(occ == 0));
`ifdef PARK_TALLY_EN
        chk("total_entries", 32'(total_entries), 32'(m_total));
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int edges;
        rst       = 1'b1;
        slots_raw = 4'd0;
        model_reset();

        // Reset state
        do_reset();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_free",  32'(free_count), 32'd4);
        tick();

        // Single arrival accepted on edge 7
        slots_raw = 4'b0001;
        for (int e = 1; e <= 6; e++) tick();
        chk("arr0_before", 32'(slots_clean), 32'h0);
        tick();
        chk("arr0_clean", 32'(slots_clean), 32'h1);
        chk("arr0_pulse", 32'(arrive), 32'h1);
        chk("arr0_free",  32'(free_count), 32'd3);
        tick();
        chk("arr0_pulse_end", 32'(arrive), 32'h0);

        // Three-cycle glitch on slot 1 is rejected
        slots_raw = 4'b0011;
        repeat (3) tick();
        slots_raw = 4'b0001;
        repeat (10) tick();
        chk("glitch_clean", 32'(slots_clean), 32'h1);
        chk("glitch_occ",   32'(occ_count), 32'd1);

        // Three simultaneous arrivals
        slots_raw = 4'b1111;
        edges = 0;
        for (int k = 0; k < 20 && arrive == 4'd0; k++) begin
            tick();
            edges++;
        end
        chk("multi_arrive", 32'(arrive), 32'hE);
        chk("multi_edges",  32'(edges), 32'd7);
        chk("multi_full",   32'(full), 32'd1);
        chk("multi_free",   32'(free_count), 32'd0);
        tick();

        // Departure of slot 2
        slots_raw = 4'b1011;
        for (int k = 0; k < 20 && depart == 4'd0; k++) tick();
        chk("dep_pulse", 32'(depart), 32'h4);
        chk("dep_full",  32'(full), 32'd0);
        chk("dep_occ",   32'(occ_count), 32'd3);
        tick();
        chk("dep_pulse_end", 32'(depart), 32'h0);

        // Reset mid-debounce on slot 3, then fresh arrival 7 edges after release
        slots_raw = 4'b0000;
        do_reset();
        repeat (2) tick();
        slots_raw = 4'b1000;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("midrst_clean", 32'(slots_clean), 32'h0);
        chk("midrst_arr",   32'(arrive), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        edges = 0;
        for (int k = 0; k < 20 && arrive != 4'b1000; k++) begin
            tick();
            edges++;
        end
        chk("midrst_arrive", 32'(arrive), 32'h8);
        chk("midrst_edges",  32'(edges), 32'd7);

        // Random levels and holds, including short glitches
        for (int n = 0; n < 60; n++) begin
            slots_raw = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 12)) tick();
        end
        repeat (12) tick();

`ifdef PARK_TALLY_EN
        // 300 single-slot arrivals saturate the tally
        slots_raw = 4'b0000;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            slots_raw = 4'b0001;
            repeat (8) tick();
            slots_raw = 4'b0000;
            repeat (8) tick();
        end
        chk("tally_sat", 32'(total_entries), 32'd255);

        // Quad arrival from 252 stops at 255
        do_reset();
        for (int n = 0; n < 63; n++) begin
            slots_raw = 4'b1111;
            repeat (8) tick();
            slots_raw = 4'b0000;
            repeat (8) tick();
        end
        chk("tally_252", 32'(total_entries), 32'd252);
        slots_raw = 4'b1111;
        repeat (8) tick();
        chk("tally_quad_sat", 32'(total_entries), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
